decoder_scan_ctrl: RTL and testbench

Scan sequencer that sits directly upstream of the 3-to-8 line decoder and drives its 3-bit select and output-polarity inputs. It steps through the enabled positions of an 8-entry mask at a programmable dwell rate and inserts one blanking cycle between positions. It flags each wrap of the sequence, so multiplexed LED/7-segment drivers can refresh a full frame without ghosting.

---
 rtl/decoder_scan_ctrl.sv | 135 +++++++++++++
 tb/tb_decoder_scan_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer for a 3-to-8 line decoder: walks the enabled positions of an
// 8-entry mask with a programmable dwell and a blanking cycle between positions.
module decoder_scan_ctrl #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  input  logic [7:0]       i_mask,
  input  logic             i_polarity,
  output logic [2:0]       o_sel,
  output logic             o_opt,
  output logic             o_blank,
  output logic             o_wrap,
  output logic             o_busy
);

  localparam int unsigned N_POS = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [DIV_W-1:0]   cnt, cnt_d;
  logic [SEL_W-1:0]   sel_d;
  logic               opt_d, blank_d, wrap_d, busy_d;
  logic [N_POS-1:0]   above;

  // Index of the lowest set bit; callers guarantee a non-zero argument.
  function automatic logic [SEL_W-1:0] lowest(input logic [N_POS-1:0] m);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = N_POS - 1; i >= 0; i--) begin
      if (m[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

  // Enabled positions strictly above the current select.
  always_comb begin
    above = '0;
    for (int i = 0; i < N_POS; i++) begin
      above[i] = i_mask[i] && (SEL_W'(i) > o_sel);
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sel_d   = o_sel;
    opt_d   = o_opt;
    blank_d = o_blank;
    wrap_d  = 1'b0;
    busy_d  = o_busy;

    if (!i_en) begin
      state_d = IDLE;
      cnt_d   = '0;
      blank_d = 1'b1;
      busy_d  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_mask != '0) begin
            state_d = DWELL;
            sel_d   = lowest(i_mask);
            cnt_d   = i_div;
            opt_d   = i_polarity;
            blank_d = 1'b0;
            busy_d  = 1'b1;
            wrap_d  = 1'b1;
          end else begin
            blank_d = 1'b1;
            busy_d  = 1'b0;
          end
        end
        DWELL: begin
          if (cnt == '0) begin
            state_d = BLANK;
            blank_d = 1'b1;
          end else begin
            cnt_d = cnt - DIV_W'(1);
          end
        end
        BLANK: begin
          if (i_mask == '0) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = DWELL;
            // No higher position left: restart the frame and flag it.
            if (above != '0) begin
              sel_d = lowest(above);
            end else begin
              sel_d  = lowest(i_mask);
              wrap_d = 1'b1;
            end
            cnt_d   = i_div;
            opt_d   = i_polarity;
            blank_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      o_sel   <= '0;
      o_opt   <= 1'b0;
      o_blank <= 1'b1;
      o_wrap  <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      o_sel   <= sel_d;
      o_opt   <= opt_d;
      o_blank <= blank_d;
      o_wrap  <= wrap_d;
      o_busy  <= busy_d;
    end
  end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Self-checking bench for decoder_scan_ctrl: vector table, directed corner cases
// and randomized scans compared against a frame-arithmetic reference.
module tb_decoder_scan_ctrl;

  localparam int unsigned DIV_W = 16;

  logic             clk = 1'b0;
  logic             rst, en, pol;
  logic [DIV_W-1:0] div;
  logic [7:0]       mask;
  logic [2:0]       sel;
  logic             opt, blank, wrap, busy;

  int total = 0;
  int bad   = 0;

  decoder_scan_ctrl #(.DIV_W(DIV_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_div(div), .i_mask(mask),
    .i_polarity(pol), .o_sel(sel), .o_opt(opt), .o_blank(blank),
    .o_wrap(wrap), .o_busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [7:0] mask;
    logic [3:0] div;
    logic       pol;
    logic [2:0] sel;
    logic       opt;
    logic       blank;
    logic       wrap;
    logic       busy;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int s, input int o, input int b,
                         input int w, input int u);
    chk({tag, ".sel"}, int'(sel), s);
    chk({tag, ".opt"}, int'(opt), o);
    chk({tag, ".blank"}, int'(blank), b);
    chk({tag, ".wrap"}, int'(wrap), w);
    chk({tag, ".busy"}, int'(busy), u);
  endtask

  // Step until an unblanked select equals s, bounded by a cycle budget.
  task automatic wait_sel(input int s);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      if (int'(sel) == s && !blank) seen = 1;
    end
    chk("wait_sel_reached", int'(seen), 1);
  endtask

  task automatic go_idle();
    en = 1'b0;
    step();
  endtask

  // Reference: with constant inputs, cycle t after the enable edge lies in
  // position slot t/(div+2) of the frame, and the last cycle of a slot is blank.
  task automatic run_model(input logic [7:0] m, input int d, input logic p, input int ncyc);
    int list[$];
    int n, per, k, ph, exp_sel;
    for (int i = 0; i < 8; i++) if (m[i]) list.push_back(i);
    n   = list.size();
    per = d + 2;
    mask = m; div = DIV_W'(d); pol = p; en = 1'b1;
    exp_sel = list[0];
    for (int t = 0; t < ncyc; t++) begin
      step();
      k  = t / per;
      ph = t % per;
      exp_sel = list[k % n];
      chk_all("model", exp_sel, int'(p), int'(ph == per - 1),
              int'((k % n == 0) && ph == 0), 1);
    end
    go_idle();
    chk_all("model_off", exp_sel, int'(p), 1, 0, 0);
  endtask

  vec_t vecs[11];

  initial begin
    rst = 1'b1; en = 1'b0; pol = 1'b0; div = '0; mask = '0;
    step();
    step();
    chk_all("reset", 0, 0, 1, 0, 0);
    rst = 1'b0;
    step();
    chk_all("idle_hold", 0, 0, 1, 0, 0);

    // Sparse mask, 1-cycle dwell, then enable drop and re-enable with full mask.
    vecs[0]  = '{1, 8'hA4, 0, 1, 2, 1, 0, 1, 1};
    vecs[1]  = '{1, 8'hA4, 0, 1, 2, 1, 1, 0, 1};
    vecs[2]  = '{1, 8'hA4, 0, 1, 5, 1, 0, 0, 1};
    vecs[3]  = '{1, 8'hA4, 0, 1, 5, 1, 1, 0, 1};
    vecs[4]  = '{1, 8'hA4, 0, 1, 7, 1, 0, 0, 1};
    vecs[5]  = '{1, 8'hA4, 0, 1, 7, 1, 1, 0, 1};
    vecs[6]  = '{1, 8'hA4, 0, 1, 2, 1, 0, 1, 1};
    vecs[7]  = '{0, 8'hA4, 0, 0, 2, 1, 1, 0, 0};
    vecs[8]  = '{0, 8'hA4, 0, 0, 2, 1, 1, 0, 0};
    vecs[9]  = '{1, 8'hFF, 0, 0, 0, 0, 0, 1, 1};
    vecs[10] = '{1, 8'hFF, 0, 0, 0, 0, 1, 0, 1};
    for (int i = 0; i < 11; i++) begin
      en = vecs[i].en; mask = vecs[i].mask; div = DIV_W'(vecs[i].div); pol = vecs[i].pol;
      step();
      chk_all($sformatf("vec%0d", i), int'(vecs[i].sel), int'(vecs[i].opt),
              int'(vecs[i].blank), int'(vecs[i].wrap), int'(vecs[i].busy));
    end
    go_idle();

    // Full scan and single-position scan against the reference.
    run_model(8'hFF, 2, 1'b1, 70);
    run_model(8'h10, 3, 1'b0, 25);

    // Reset mid-dwell at select 5.
    mask = 8'hFF; div = DIV_W'(3); pol = 1'b1; en = 1'b1;
    wait_sel(5);
    rst = 1'b1;
    step();
    chk_all("rst_mid", 0, 0, 1, 0, 0);
    rst = 1'b0; en = 1'b0;
    step();

    // Mask cleared mid-dwell: dwell finishes, one blank, then idle.
    mask = 8'hFF; div = DIV_W'(3); pol = 1'b0; en = 1'b1;
    step();
    step();
    mask = 8'h00;
    step(); chk_all("mz_t2", 0, 0, 0, 0, 1);
    step(); chk_all("mz_t3", 0, 0, 0, 0, 1);
    step(); chk_all("mz_blank", 0, 0, 1, 0, 1);
    step(); chk_all("mz_idle", 0, 0, 1, 0, 0);
    step(); chk_all("mz_stay", 0, 0, 1, 0, 0);
    go_idle();

    // Enable drop mid-dwell at select 3, then re-enable.
    mask = 8'hFF; div = DIV_W'(3); pol = 1'b1; en = 1'b1;
    wait_sel(3);
    step();
    en = 1'b0;
    step(); chk_all("drop", 3, 1, 1, 0, 0);
    en = 1'b1; mask = 8'hFF;
    step(); chk_all("reen", 0, 1, 0, 1, 1);
    go_idle();

    // Polarity only takes effect at the next dwell entry.
    mask = 8'h03; div = DIV_W'(3); pol = 1'b0; en = 1'b1;
    step(); chk_all("pol_entry", 0, 0, 0, 1, 1);
    pol = 1'b1;
    for (int t = 1; t < 5; t++) begin
      step();
      chk("pol_hold", int'(opt), 0);
    end
    step(); chk_all("pol_new", 1, 1, 0, 0, 1);
    go_idle();

    // Randomized scans with constant inputs per run.
    for (int r = 0; r < 12; r++) begin
      logic [7:0] m;
      m = 8'($urandom_range(1, 255));
      run_model(m, int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                int'($urandom_range(10, 80)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
